// File: rtl/phy_regfile.sv
// phy_regfile: physical register file with per-entry data-valid bitmap.
// Writeback ports set data and valid, rename ports clear valid, flush sets
// every valid bit. Reads are combinational with same-cycle writeback bypass.
// Entry 0 is the hardwired zero register.

`ifndef PHY_REG_NUM
`define PHY_REG_NUM 64
`endif
`ifndef PHY_REG_ID_WIDTH
`define PHY_REG_ID_WIDTH 6
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef WB_WIDTH
`define WB_WIDTH 4
`endif
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif

module phy_regfile #(
  parameter int PHY_REG_NUM = `PHY_REG_NUM,
  parameter int ID_W        = `PHY_REG_ID_WIDTH,
  parameter int DATA_W      = `REG_DATA_WIDTH,
  parameter int WB_PORT_NUM = `WB_WIDTH,
  parameter int RD_PORT_NUM = 4,
  parameter int RN_PORT_NUM = `RENAME_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ID_W-1:0]        wb_phyf_id      [0:WB_PORT_NUM-1],
  input  logic [DATA_W-1:0]      wb_phyf_data    [0:WB_PORT_NUM-1],
  input  logic [WB_PORT_NUM-1:0] wb_phyf_we,
  input  logic [ID_W-1:0]        rn_phyf_id      [0:RN_PORT_NUM-1],
  input  logic [RN_PORT_NUM-1:0] rn_phyf_invalid,
  input  logic                   flush,
  input  logic [ID_W-1:0]        rd_phyf_id      [0:RD_PORT_NUM-1],
  output logic [DATA_W-1:0]      rd_phyf_data    [0:RD_PORT_NUM-1],
  output logic [RD_PORT_NUM-1:0] rd_phyf_valid
);

  logic [DATA_W-1:0]      data [PHY_REG_NUM];
  logic [PHY_REG_NUM-1:0] valid;

  // True for an id that names a real, writable entry (not zero, not out of range).
  function automatic logic id_ok(input logic [ID_W-1:0] id);
    return (id != '0) && (32'(id) < PHY_REG_NUM);
  endfunction

  // Storage update: writeback data/valid, then rename clears, then flush.
  // NOTE: every entry is reset here because reads right after reset must
  // return 0/1 for any id; this storage is flops, not a RAM macro, so a
  // reset on the whole array is legal and intended.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHY_REG_NUM; i++) data[i] <= '0;
      valid <= '1;
    end else begin
      // NOTE: non-blocking assignments to the same element within one block
      // resolve to the last one executed, so loop order and statement order
      // encode priority: higher writeback port over lower, clear over write,
      // flush over clear.
      for (int k = 0; k < WB_PORT_NUM; k++) begin
        if (wb_phyf_we[k] && id_ok(wb_phyf_id[k])) begin
          data[wb_phyf_id[k]]  <= wb_phyf_data[k];
          valid[wb_phyf_id[k]] <= 1'b1;
        end
      end
      for (int j = 0; j < RN_PORT_NUM; j++) begin
        if (rn_phyf_invalid[j] && id_ok(rn_phyf_id[j])) valid[rn_phyf_id[j]] <= 1'b0;
      end
      if (flush) valid <= '1;
    end
  end

  // Read ports: zero register, storage, then highest matching writeback bypass.
  // NOTE: every output gets a default at the top so no path infers a latch.
  always_comb begin
    for (int r = 0; r < RD_PORT_NUM; r++) begin
      rd_phyf_data[r]  = '0;
      rd_phyf_valid[r] = 1'b0;
      if (rd_phyf_id[r] == '0) begin
        rd_phyf_valid[r] = 1'b1;
      end else if (id_ok(rd_phyf_id[r])) begin
        rd_phyf_data[r]  = data[rd_phyf_id[r]];
        rd_phyf_valid[r] = valid[rd_phyf_id[r]];
        for (int k = 0; k < WB_PORT_NUM; k++) begin
          if (wb_phyf_we[k] && (wb_phyf_id[k] == rd_phyf_id[r])) begin
            rd_phyf_data[r]  = wb_phyf_data[k];
            rd_phyf_valid[r] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_phy_regfile.sv
// Self-checking bench for phy_regfile: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the register file.

module tb_phy_regfile;

  localparam int N  = 64;
  localparam int IW = 6;
  localparam int DW = 32;
  localparam int WB = 4;
  localparam int RD = 4;
  localparam int RN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] wb_phyf_id   [0:WB-1];
  logic [DW-1:0] wb_phyf_data [0:WB-1];
  logic [WB-1:0] wb_phyf_we;
  logic [IW-1:0] rn_phyf_id   [0:RN-1];
  logic [RN-1:0] rn_phyf_invalid;
  logic          flush;
  logic [IW-1:0] rd_phyf_id   [0:RD-1];
  logic [DW-1:0] rd_phyf_data [0:RD-1];
  logic [RD-1:0] rd_phyf_valid;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [DW-1:0] m_data  [N];
  bit            m_valid [N];

  phy_regfile dut (
    .clk             (clk),
    .rst             (rst),
    .wb_phyf_id      (wb_phyf_id),
    .wb_phyf_data    (wb_phyf_data),
    .wb_phyf_we      (wb_phyf_we),
    .rn_phyf_id      (rn_phyf_id),
    .rn_phyf_invalid (rn_phyf_invalid),
    .flush           (flush),
    .rd_phyf_id      (rd_phyf_id),
    .rd_phyf_data    (rd_phyf_data),
    .rd_phyf_valid   (rd_phyf_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_data[i]  = '0;
      m_valid[i] = 1'b1;
    end
  endtask

  // Clock-edge effect of the current inputs, stated entry by entry.
  task automatic model_update();
    for (int idx = 1; idx < N; idx++) begin
      bit wr = 1'b0;
      bit clr = 1'b0;
      for (int k = 0; k < WB; k++)
        if (wb_phyf_we[k] && int'(wb_phyf_id[k]) == idx) begin
          m_data[idx] = wb_phyf_data[k];
          wr = 1'b1;
        end
      for (int j = 0; j < RN; j++)
        if (rn_phyf_invalid[j] && int'(rn_phyf_id[j]) == idx) clr = 1'b1;
      if (flush)    m_valid[idx] = 1'b1;
      else if (clr) m_valid[idx] = 1'b0;
      else if (wr)  m_valid[idx] = 1'b1;
    end
  endtask

  task automatic read_exp(input int r, output logic [DW-1:0] d, output logic v);
    int id = int'(rd_phyf_id[r]);
    if (id == 0) begin
      d = '0;
      v = 1'b1;
    end else begin
      d = m_data[id];
      v = m_valid[id];
      for (int k = 0; k < WB; k++)
        if (wb_phyf_we[k] && int'(wb_phyf_id[k]) == id) begin
          d = wb_phyf_data[k];
          v = 1'b1;
        end
    end
  endtask

  task automatic compare_all();
    logic [DW-1:0] d;
    logic          v;
    for (int r = 0; r < RD; r++) begin
      read_exp(r, d, v);
      check($sformatf("rd_data[%0d] id=%0d", r, rd_phyf_id[r]), 64'(rd_phyf_data[r]), 64'(d));
      check($sformatf("rd_valid[%0d] id=%0d", r, rd_phyf_id[r]), 64'(rd_phyf_valid[r]), 64'(v));
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    compare_all();
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) model_update();
    #1;
  endtask

  task automatic idle_inputs();
    wb_phyf_we      = '0;
    rn_phyf_invalid = '0;
    flush           = 1'b0;
    for (int k = 0; k < WB; k++) begin
      wb_phyf_id[k]   = '0;
      wb_phyf_data[k] = '0;
    end
    for (int j = 0; j < RN; j++) rn_phyf_id[j] = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    for (int r = 0; r < RD; r++) rd_phyf_id[r] = IW'(r);
    model_reset();

    // Reset held for two cycles: ids 0..3 read 0/1.
    at_neg();
    for (int r = 0; r < RD; r++) begin
      check($sformatf("reset data id%0d", r), 64'(rd_phyf_data[r]), 64'h0);
      check($sformatf("reset valid id%0d", r), 64'(rd_phyf_valid[r]), 64'h1);
    end
    adv();
    at_neg();
    adv();
    rst = 1'b1;

    // Full-width writeback with bypass, then from storage.
    wb_phyf_we = '1;
    for (int k = 0; k < WB; k++) begin
      wb_phyf_id[k]   = IW'(k + 1);
      wb_phyf_data[k] = 32'h15263317 + 32'(k + 1);
    end
    for (int r = 0; r < RD; r++) rd_phyf_id[r] = IW'(r + 1);
    at_neg();
    for (int r = 0; r < RD; r++) begin
      check($sformatf("bypass data p%0d", r), 64'(rd_phyf_data[r]), 64'(32'h15263317 + 32'(r + 1)));
      check($sformatf("bypass valid p%0d", r), 64'(rd_phyf_valid[r]), 64'h1);
    end
    adv();
    wb_phyf_we = '0;
    at_neg();
    for (int r = 0; r < RD; r++) begin
      check($sformatf("stored data p%0d", r), 64'(rd_phyf_data[r]), 64'(32'h15263317 + 32'(r + 1)));
      check($sformatf("stored valid p%0d", r), 64'(rd_phyf_valid[r]), 64'h1);
    end
    adv();

    // Allocate id 5, then complete it.
    rn_phyf_invalid[0] = 1'b1;
    rn_phyf_id[0]      = 6'd5;
    rd_phyf_id[0]      = 6'd5;
    at_neg();
    adv();
    rn_phyf_invalid = '0;
    at_neg();
    check("alloc valid id5", 64'(rd_phyf_valid[0]), 64'h0);
    check("alloc data id5", 64'(rd_phyf_data[0]), 64'h0);
    adv();
    wb_phyf_we[0]   = 1'b1;
    wb_phyf_id[0]   = 6'd5;
    wb_phyf_data[0] = 32'hDEADBEEF;
    at_neg();
    check("complete bypass data", 64'(rd_phyf_data[0]), 64'hDEADBEEF);
    check("complete bypass valid", 64'(rd_phyf_valid[0]), 64'h1);
    adv();
    wb_phyf_we = '0;
    at_neg();
    check("complete stored data", 64'(rd_phyf_data[0]), 64'hDEADBEEF);
    check("complete stored valid", 64'(rd_phyf_valid[0]), 64'h1);
    adv();

    // Two writeback ports hit id 7: port 1 wins.
    wb_phyf_we      = 4'b0011;
    wb_phyf_id[0]   = 6'd7;
    wb_phyf_data[0] = 32'h11;
    wb_phyf_id[1]   = 6'd7;
    wb_phyf_data[1] = 32'h22;
    rd_phyf_id[0]   = 6'd7;
    at_neg();
    check("collide bypass", 64'(rd_phyf_data[0]), 64'h22);
    adv();
    wb_phyf_we = '0;
    at_neg();
    check("collide stored", 64'(rd_phyf_data[0]), 64'h22);
    check("collide valid", 64'(rd_phyf_valid[0]), 64'h1);
    adv();

    // Clear and write of id 9 in one cycle: clear wins valid, data written.
    wb_phyf_we         = 4'b0001;
    wb_phyf_id[0]      = 6'd9;
    wb_phyf_data[0]    = 32'h99;
    rn_phyf_invalid[0] = 1'b1;
    rn_phyf_id[0]      = 6'd9;
    rd_phyf_id[0]      = 6'd9;
    at_neg();
    adv();
    wb_phyf_we      = '0;
    rn_phyf_invalid = '0;
    at_neg();
    check("clr+wr valid id9", 64'(rd_phyf_valid[0]), 64'h0);
    check("clr+wr data id9", 64'(rd_phyf_data[0]), 64'h99);
    adv();

    // Clear 10..13, then flush alongside a clear of 14.
    rn_phyf_invalid = '1;
    for (int j = 0; j < RN; j++) begin
      rn_phyf_id[j] = IW'(10 + j);
      rd_phyf_id[j] = IW'(10 + j);
    end
    at_neg();
    adv();
    rn_phyf_invalid = 4'b0001;
    rn_phyf_id[0]   = 6'd14;
    flush           = 1'b1;
    at_neg();
    check("pre-flush valid id10", 64'(rd_phyf_valid[0]), 64'h0);
    adv();
    rn_phyf_invalid = '0;
    flush           = 1'b0;
    at_neg();
    for (int r = 0; r < RD; r++)
      check($sformatf("flush valid id%0d", 10 + r), 64'(rd_phyf_valid[r]), 64'h1);
    adv();
    rd_phyf_id[0] = 6'd14;
    at_neg();
    check("flush valid id14", 64'(rd_phyf_valid[0]), 64'h1);
    adv();

    // Entry 0 ignores writes.
    wb_phyf_we      = 4'b0001;
    wb_phyf_id[0]   = 6'd0;
    wb_phyf_data[0] = 32'h1234;
    rd_phyf_id[0]   = 6'd0;
    at_neg();
    check("zero bypass data", 64'(rd_phyf_data[0]), 64'h0);
    check("zero bypass valid", 64'(rd_phyf_valid[0]), 64'h1);
    adv();
    wb_phyf_we = '0;
    at_neg();
    check("zero stored data", 64'(rd_phyf_data[0]), 64'h0);
    adv();

    // Asynchronous reset between edges clears id 3 immediately.
    wb_phyf_we      = 4'b0001;
    wb_phyf_id[0]   = 6'd3;
    wb_phyf_data[0] = 32'h55;
    adv();
    wb_phyf_we    = '0;
    rd_phyf_id[0] = 6'd3;
    at_neg();
    check("pre-reset data id3", 64'(rd_phyf_data[0]), 64'h55);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("async reset data id3", 64'(rd_phyf_data[0]), 64'h0);
    check("async reset valid id3", 64'(rd_phyf_valid[0]), 64'h1);
    adv();
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bit narrow = ($urandom_range(0, 1) == 1);
      wb_phyf_we      = WB'($urandom);
      rn_phyf_invalid = ($urandom_range(0, 3) == 0) ? RN'($urandom) : '0;
      flush           = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < WB; k++) begin
        wb_phyf_id[k]   = narrow ? IW'($urandom_range(0, 15)) : IW'($urandom);
        wb_phyf_data[k] = $urandom;
      end
      for (int j = 0; j < RN; j++)
        rn_phyf_id[j] = narrow ? IW'($urandom_range(0, 15)) : IW'($urandom);
      for (int r = 0; r < RD; r++)
        rd_phyf_id[r] = narrow ? IW'($urandom_range(0, 15)) : IW'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      at_neg();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
